// File: rtl/tage_fold_history_pkg.sv
// Shared types and sizing for the TAGE folded-history unit.
package tage_fold_history_pkg;

  localparam int unsigned GHIST_SIZE  = 256;  // must be a power of 2
  localparam int unsigned GHIST_PTR_W = $clog2(GHIST_SIZE);
  localparam int unsigned TAGE_BANK   = 4;
  localparam int unsigned IDX_W       = 11;
  localparam int unsigned TAG1_W      = 12;
  localparam int unsigned TAG2_W      = 10;

  // History length per bank; bank 0 sits in the least-significant slot.
  localparam logic [TAGE_BANK-1:0][31:0] HIST_LEN = {32'd64, 32'd32, 32'd16, 32'd8};

  typedef struct packed {
    logic [TAGE_BANK-1:0][IDX_W-1:0]  fold_idx;
    logic [TAGE_BANK-1:0][TAG1_W-1:0] fold_tag1;
    logic [TAGE_BANK-1:0][TAG2_W-1:0] fold_tag2;
  } TageFoldHist;

endpackage

// File: rtl/tage_fold_history_fold_step.sv
// One single-bit update of a W-bit fold over an L-bit history window.
module tage_fold_history_fold_step #(
  parameter int unsigned W = 11,
  parameter int unsigned L = 8
) (
  input  logic [W-1:0] f,
  input  logic         n,
  input  logic         old,
  output logic [W-1:0] f_next
);

  // The bit leaving the window was last placed at position L mod W after L rotations.
  localparam int unsigned Shift = L % W;

  assign f_next = {f[W-2:0], f[W-1]} ^ W'(n) ^ (W'(old) << Shift);

endmodule

// File: rtl/tage_fold_history.sv
// Speculative global history plus per-bank folded histories for TAGE.
// Advances by up to two outcomes per cycle; redirects restore from an FTQ snapshot.
module tage_fold_history
  import tage_fold_history_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   pred_valid,
  input  logic [1:0]             pred_shift_num,
  input  logic                   pred_taken,
  input  logic                   redirect_valid,
  input  logic [GHIST_PTR_W-1:0] redirect_ptr,
  input  TageFoldHist            redirect_fold,
  input  logic [1:0]             redirect_shift_num,
  input  logic                   redirect_taken,
  output TageFoldHist            hist,
  output logic [GHIST_PTR_W-1:0] ghist_ptr
);

  logic [GHIST_SIZE-1:0]  ghist_q, ghist_d;
  logic [GHIST_PTR_W-1:0] ptr_q, ptr_d;
  TageFoldHist            hist_q, hist_d;

  logic                   upd;
  logic [GHIST_PTR_W-1:0] base_ptr;
  TageFoldHist            base_fold;
  logic [1:0]             shift_num;
  logic                   taken;

  logic                   one_step, two_step;
  logic [GHIST_PTR_W-1:0] p0, p1;
  logic                   n0, n1;

  TageFoldHist            hist_s1, hist_s2;

  // Pick the update source: redirect beats prediction, stall only gates prediction.
  always_comb begin
    upd       = 1'b0;
    base_ptr  = ptr_q;
    base_fold = hist_q;
    shift_num = 2'd0;
    taken     = 1'b0;
    if (redirect_valid) begin
      upd       = 1'b1;
      base_ptr  = redirect_ptr;
      base_fold = redirect_fold;
      shift_num = redirect_shift_num;
      taken     = redirect_taken;
    end else if (pred_valid && !stall) begin
      upd       = 1'b1;
      shift_num = pred_shift_num;
      taken     = pred_taken;
    end
  end

  // shift_num of 3 is out of range and is treated as 2.
  assign one_step = (shift_num != 2'd0);
  assign two_step = shift_num[1];
  assign p0       = base_ptr;
  assign p1       = base_ptr + GHIST_PTR_W'(1);
  // Only the last shifted bit carries the outcome; earlier bits are not-taken.
  assign n0       = two_step ? 1'b0 : taken;
  assign n1       = taken;

  for (genvar b = 0; b < TAGE_BANK; b++) begin : g_bank
    localparam int unsigned L = int'(HIST_LEN[b]);

    logic old0, old1;
    // Step 1 writes p0, step 2 reads p1-L; these never alias because L > 1.
    assign old0 = ghist_q[p0 - GHIST_PTR_W'(L)];
    assign old1 = ghist_q[p1 - GHIST_PTR_W'(L)];

    tage_fold_history_fold_step #(.W(IDX_W), .L(L)) u_idx_s1 (
      .f      (base_fold.fold_idx[b]),
      .n      (n0),
      .old    (old0),
      .f_next (hist_s1.fold_idx[b])
    );
    tage_fold_history_fold_step #(.W(IDX_W), .L(L)) u_idx_s2 (
      .f      (hist_s1.fold_idx[b]),
      .n      (n1),
      .old    (old1),
      .f_next (hist_s2.fold_idx[b])
    );
    tage_fold_history_fold_step #(.W(TAG1_W), .L(L)) u_tag1_s1 (
      .f      (base_fold.fold_tag1[b]),
      .n      (n0),
      .old    (old0),
      .f_next (hist_s1.fold_tag1[b])
    );
    tage_fold_history_fold_step #(.W(TAG1_W), .L(L)) u_tag1_s2 (
      .f      (hist_s1.fold_tag1[b]),
      .n      (n1),
      .old    (old1),
      .f_next (hist_s2.fold_tag1[b])
    );
    tage_fold_history_fold_step #(.W(TAG2_W), .L(L)) u_tag2_s1 (
      .f      (base_fold.fold_tag2[b]),
      .n      (n0),
      .old    (old0),
      .f_next (hist_s1.fold_tag2[b])
    );
    tage_fold_history_fold_step #(.W(TAG2_W), .L(L)) u_tag2_s2 (
      .f      (hist_s1.fold_tag2[b]),
      .n      (n1),
      .old    (old1),
      .f_next (hist_s2.fold_tag2[b])
    );
  end

  // Next state: commit 0, 1 or 2 steps on top of the selected base.
  always_comb begin
    ghist_d = ghist_q;
    ptr_d   = ptr_q;
    hist_d  = hist_q;
    if (upd) begin
      if (two_step) begin
        hist_d      = hist_s2;
        ptr_d       = base_ptr + GHIST_PTR_W'(2);
        ghist_d[p0] = n0;
        ghist_d[p1] = n1;
      end else if (one_step) begin
        hist_d      = hist_s1;
        ptr_d       = base_ptr + GHIST_PTR_W'(1);
        ghist_d[p0] = n0;
      end else begin
        hist_d = base_fold;
        ptr_d  = base_ptr;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghist_q <= '0;
      ptr_q   <= '0;
      hist_q  <= '0;
    end else begin
      ghist_q <= ghist_d;
      ptr_q   <= ptr_d;
      hist_q  <= hist_d;
    end
  end

  assign hist      = hist_q;
  assign ghist_ptr = ptr_q;

endmodule

// File: tb/tb_tage_fold_history.sv
// Self-checking bench for tage_fold_history: directed table, corner sequences,
// and a randomized run against a full-history reference model.
module tb_tage_fold_history;
  import tage_fold_history_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   stall;
  logic                   pred_valid;
  logic [1:0]             pred_shift_num;
  logic                   pred_taken;
  logic                   redirect_valid;
  logic [GHIST_PTR_W-1:0] redirect_ptr;
  TageFoldHist            redirect_fold;
  logic [1:0]             redirect_shift_num;
  logic                   redirect_taken;
  TageFoldHist            hist;
  logic [GHIST_PTR_W-1:0] ghist_ptr;

  always #5 clk = ~clk;

  tage_fold_history u_dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .pred_valid         (pred_valid),
    .pred_shift_num     (pred_shift_num),
    .pred_taken         (pred_taken),
    .redirect_valid     (redirect_valid),
    .redirect_ptr       (redirect_ptr),
    .redirect_fold      (redirect_fold),
    .redirect_shift_num (redirect_shift_num),
    .redirect_taken     (redirect_taken),
    .hist               (hist),
    .ghist_ptr          (ghist_ptr)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: raw history buffer and pointer; folds computed from scratch.
  bit mhist [GHIST_SIZE];
  int mptr;

  function automatic TageFoldHist model_fold();
    TageFoldHist h;
    h = '0;
    for (int b = 0; b < TAGE_BANK; b++) begin
      for (int i = 0; i < int'(HIST_LEN[b]); i++) begin
        logic bt;
        bt = mhist[(mptr - 1 - i) & (GHIST_SIZE - 1)];
        h.fold_idx[b][i % IDX_W]   ^= bt;
        h.fold_tag1[b][i % TAG1_W] ^= bt;
        h.fold_tag2[b][i % TAG2_W] ^= bt;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < GHIST_SIZE; i++) mhist[i] = 1'b0;
    mptr = 0;
  endtask

  task automatic model_shift(input int k, input bit t);
    for (int j = 0; j < k; j++) begin
      mhist[mptr] = (j == k - 1) ? t : 1'b0;
      mptr = (mptr + 1) % GHIST_SIZE;
    end
  endtask

  task automatic check_state(input string name);
    TageFoldHist exp;
    exp = model_fold();
    checks++;
    if (hist !== exp || ghist_ptr !== GHIST_PTR_W'(mptr)) begin
      failures++;
      $display("FAIL %s: got ptr=%0d hist=%h, expected ptr=%0d hist=%h",
               name, ghist_ptr, hist, mptr, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model the same way, leave time at edge+1.
  task automatic drive(input bit r, input bit s, input bit pv, input logic [1:0] k,
                       input bit t, input bit rv, input int rp, input TageFoldHist rf,
                       input logic [1:0] rk, input bit rt);
    rst                = r;
    stall              = s;
    pred_valid         = pv;
    pred_shift_num     = k;
    pred_taken         = t;
    redirect_valid     = rv;
    redirect_ptr       = GHIST_PTR_W'(rp);
    redirect_fold      = rf;
    redirect_shift_num = rk;
    redirect_taken     = rt;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else if (rv) begin
      mptr = rp;
      model_shift(int'(rk), rt);
    end else if (pv && !s) model_shift(int'(k), t);
  endtask

  task automatic pred(input bit s, input logic [1:0] k, input bit t);
    drive(1'b0, s, 1'b1, k, t, 1'b0, 0, '0, 2'd0, 1'b0);
  endtask

  typedef struct {
    bit          stall;
    bit          pv;
    logic [1:0]  k;
    bit          t;
    int          exp_ptr;
    logic [10:0] exp_idx0;
    logic [10:0] exp_idx1;
  } vec_t;

  vec_t vecs[$];

  // Snapshot ring for the randomized phase.
  TageFoldHist snap_hr [32];
  int          snap_pr [32];
  int          head;
  int          cnt;

  initial begin
    TageFoldHist snap_h;
    int          snap_p;

    // Saturate bank 0, fold bank 1 over 16 taken bits, with stall and k=0 in between.
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  1, 11'h001, 11'h001});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  2, 11'h003, 11'h003});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  3, 11'h007, 11'h007});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  4, 11'h00F, 11'h00F});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  5, 11'h01F, 11'h01F});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  6, 11'h03F, 11'h03F});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  7, 11'h07F, 11'h07F});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  8, 11'h0FF, 11'h0FF});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1,  9, 11'h0FF, 11'h1FF});
    vecs.push_back('{1'b1, 1'b1, 2'd2, 1'b1,  9, 11'h0FF, 11'h1FF});
    vecs.push_back('{1'b0, 1'b1, 2'd0, 1'b1,  9, 11'h0FF, 11'h1FF});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 10, 11'h0FF, 11'h3FF});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 11, 11'h0FF, 11'h7FF});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 12, 11'h0FF, 11'h7FE});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 13, 11'h0FF, 11'h7FC});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 14, 11'h0FF, 11'h7F8});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 15, 11'h0FF, 11'h7F0});
    vecs.push_back('{1'b0, 1'b1, 2'd1, 1'b1, 16, 11'h0FF, 11'h7E0});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 18, 11'h0FC, 11'h7E3});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 20, 11'h0F0, 11'h7EF});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 22, 11'h0C0, 11'h7DF});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 24, 11'h000, 11'h71F});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 26, 11'h000, 11'h41F});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 28, 11'h000, 11'h01E});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 30, 11'h000, 11'h018});
    vecs.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 32, 11'h000, 11'h000});

    // Reset
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, '0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 0, '0, 2'd0, 1'b0);
    rst = 1'b0;
    check_val("reset_ptr", 32'(ghist_ptr), 32'd0);
    check_state("reset_hist");

    // Directed table
    foreach (vecs[i]) begin
      pred(vecs[i].stall, vecs[i].k, vecs[i].t);
      check_val($sformatf("vec%0d_ptr", i), 32'(ghist_ptr), 32'(vecs[i].exp_ptr));
      check_val($sformatf("vec%0d_idx0", i), 32'(hist.fold_idx[0]), 32'(vecs[i].exp_idx0));
      check_val($sformatf("vec%0d_idx1", i), 32'(hist.fold_idx[1]), 32'(vecs[i].exp_idx1));
      check_state($sformatf("vec%0d_model", i));
    end

    // Wrap-around: walk ptr 32 -> 254 -> 255, then two bits across the boundary.
    for (int i = 0; i < 111; i++) begin
      pred(1'b0, 2'd2, 1'($urandom % 2));
      check_state("walk");
    end
    pred(1'b0, 2'd1, 1'b0);
    check_val("wrap_pre_ptr", 32'(ghist_ptr), 32'd255);
    pred(1'b0, 2'd2, 1'b1);
    check_val("wrap_ptr", 32'(ghist_ptr), 32'd1);
    check_val("wrap_model_bit255", 32'(mhist[255]), 32'd0);
    check_val("wrap_model_bit0", 32'(mhist[0]), 32'd1);
    check_state("wrap_fold");

    // Redirect: snapshot at ptr 5, 10 wrong-path taken bits, then restore + 1 not-taken.
    for (int i = 0; i < 4; i++) pred(1'b0, 2'd1, 1'b1);
    snap_p = mptr;
    snap_h = model_fold();
    check_val("snap_ptr", 32'(ghist_ptr), 32'd5);
    for (int i = 0; i < 10; i++) pred(1'b0, 2'd1, 1'b1);
    check_val("wrong_path_ptr", 32'(ghist_ptr), 32'd15);
    drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, snap_p, snap_h, 2'd1, 1'b0);
    check_val("redirect_ptr", 32'(ghist_ptr), 32'd6);
    check_state("redirect_fold");

    // Redirect under stall with k=0 must land exactly on the snapshot.
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b1, snap_p, snap_h, 2'd0, 1'b0);
    check_val("redirect_k0_ptr", 32'(ghist_ptr), 32'd5);
    checks++;
    if (hist !== snap_h) begin
      failures++;
      $display("FAIL redirect_k0_hist: got %h, expected %h", hist, snap_h);
    end
    drive(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, snap_p, snap_h, 2'd2, 1'b1);
    check_val("redirect_k2_ptr", 32'(ghist_ptr), 32'd7);
    check_state("redirect_k2_fold");

    // Reset mid-stream overrides a simultaneous redirect and prediction.
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, snap_p, snap_h, 2'd2, 1'b1);
    check_val("midreset_ptr", 32'(ghist_ptr), 32'd0);
    checks++;
    if (hist !== '0) begin
      failures++;
      $display("FAIL midreset_hist: got %h, expected 0", hist);
    end

    // Randomized predictions and redirects against the reference model.
    head = 0;
    cnt  = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r, rv;
      int idx;
      snap_hr[head] = model_fold();
      snap_pr[head] = mptr;
      head = (head + 1) % 32;
      if (cnt < 32) cnt++;
      r   = (cyc == 1500);
      rv  = ($urandom % 8) == 0;
      idx = (head - 1 - int'($urandom % cnt) + 64) % 32;
      drive(r, ($urandom % 4) == 0, ($urandom % 4) != 0, 2'($urandom % 3),
            1'($urandom % 2), rv, snap_pr[idx], snap_hr[idx], 2'($urandom % 3),
            1'($urandom % 2));
      check_state($sformatf("rand%0d", cyc));
      // Older snapshots may sit on a discarded path once history is rewritten.
      if (r || rv) cnt = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
